// File: rtl/cpu_pkg.sv
// Shared widths, memory-stage FSM encoding and MEM/WB record for the 8-bit pipeline.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] rd;
    logic              we;
  } memwb_t;

  function automatic logic [DATA_W-1:0] wb_select(
    input logic              use_mem,
    input logic [DATA_W-1:0] mem_val,
    input logic [DATA_W-1:0] alu_val
  );
    logic [DATA_W-1:0] res;
    if (use_mem) begin
      res = mem_val;
    end else begin
      res = alu_val;
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Data memory for the MEM stage: DEPTH x DATA_W, synchronous write, asynchronous read.
module data_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Array is intentionally not reset so contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: wait-state FSM, upstream stall, MEM/WB register and
// forwarding taps around the internal data memory.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     ex_valid,
  input  logic signed [DATA_W-1:0] alu_result,
  input  logic signed [DATA_W-1:0] store_data,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic                     mem_to_reg,
  input  logic                     reg_write_in,
  input  logic [REG_AW-1:0]        rd_in,
  output logic                     stall,
  output logic signed [DATA_W-1:0] fwd_data_mem,
  output logic [REG_AW-1:0]        fwd_rd_mem,
  output logic                     fwd_we_mem,
  output logic signed [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0]        wb_rd,
  output logic                     wb_reg_write
);

  localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam bit               HAS_WAIT = (WAIT_STATES > 0);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  memwb_t            wb_q, wb_d;
  logic              mem_op_s, stall_s, complete_s, mem_we_s, use_mem_s;
  logic [AW-1:0]     addr_s;
  logic [DATA_W-1:0] rdata_s;

  assign mem_op_s = ex_valid & (mem_read | mem_write) & ~flush;
  assign addr_s   = alu_result[AW-1:0];

  // Flush outranks completion; a completing op is the only thing that writes memory or MEM/WB.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_s    = 1'b0;
    complete_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_s && HAS_WAIT) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_LOAD;
          stall_s = 1'b1;
        end else if (!flush) begin
          complete_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_IDLE;
          cnt_d      = CNT_ZERO;
          complete_s = 1'b1;
        end else begin
          cnt_d   = cnt_q - CNT_LAST;
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  assign mem_we_s  = complete_s & mem_op_s & mem_write & ~reset;
  // A combined read+write is treated as a store, so write-back takes the ALU value.
  assign use_mem_s = mem_to_reg & ~(mem_read & mem_write);

  // Non-completing cycles insert a bubble while data and rd hold.
  always_comb begin
    wb_d = wb_q;
    if (complete_s) begin
      wb_d.data = wb_select(use_mem_s, rdata_s, alu_result);
      wb_d.rd   = rd_in;
      wb_d.we   = reg_write_in & ex_valid;
    end else begin
      wb_d.we = 1'b0;
    end
  end

  // FSM, wait counter and MEM/WB register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      wb_q    <= {$bits(memwb_t){1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
    end
  end

  data_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_data_mem (
    .clk     (clk),
    .we_i    (mem_we_s),
    .addr_i  (addr_s),
    .wdata_i (store_data),
    .rdata_o (rdata_s)
  );

  assign stall        = stall_s & ~reset;
  assign fwd_data_mem = alu_result;
  assign fwd_rd_mem   = rd_in;
  assign fwd_we_mem   = reg_write_in & ex_valid;
  assign wb_data      = wb_q.data;
  assign wb_rd        = wb_q.rd;
  assign wb_reg_write = wb_q.we;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a 16-entry/2-wait-state instance and a
// 256-entry/0-wait-state instance, exercised one after the other.
module tb_mem_stage;

  logic clk;
  logic reset;
  logic [1:0]      flush_v, ev_v, mrd_v, mwr_v, m2r_v, rw_v;
  logic [1:0]      stall_v, fwe_v, wbwe_v;
  logic [1:0][7:0] alu_v, sd_v, fwd_v, wbd_v;
  logic [1:0][2:0] rd_v, frd_v, wbrd_v;

  typedef struct {
    int         k;
    logic [7:0] data;
    logic [2:0] rd;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] mm [2][256];
  int         n_cmp;
  int         n_bad;

  mem_stage #(.DEPTH(16), .WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .reset(reset), .flush(flush_v[0]), .ex_valid(ev_v[0]),
    .alu_result(alu_v[0]), .store_data(sd_v[0]), .mem_read(mrd_v[0]),
    .mem_write(mwr_v[0]), .mem_to_reg(m2r_v[0]), .reg_write_in(rw_v[0]),
    .rd_in(rd_v[0]), .stall(stall_v[0]), .fwd_data_mem(fwd_v[0]),
    .fwd_rd_mem(frd_v[0]), .fwd_we_mem(fwe_v[0]), .wb_data(wbd_v[0]),
    .wb_rd(wbrd_v[0]), .wb_reg_write(wbwe_v[0])
  );

  mem_stage #(.DEPTH(256), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .reset(reset), .flush(flush_v[1]), .ex_valid(ev_v[1]),
    .alu_result(alu_v[1]), .store_data(sd_v[1]), .mem_read(mrd_v[1]),
    .mem_write(mwr_v[1]), .mem_to_reg(m2r_v[1]), .reg_write_in(rw_v[1]),
    .rd_in(rd_v[1]), .stall(stall_v[1]), .fwd_data_mem(fwd_v[1]),
    .fwd_rd_mem(frd_v[1]), .fwd_we_mem(fwe_v[1]), .wb_data(wbd_v[1]),
    .wb_rd(wbrd_v[1]), .wb_reg_write(wbwe_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(input int k);
    return (k == 0) ? 16 : 256;
  endfunction

  function automatic int ws(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle(input int k);
    ev_v[k] = 1'b0; mrd_v[k] = 1'b0; mwr_v[k] = 1'b0;
    m2r_v[k] = 1'b0; rw_v[k] = 1'b0; flush_v[k] = 1'b0;
  endtask

  // One instruction: drive, wait out the stall, predict the write-back, drop inputs after completion.
  task automatic issue(input int k, input bit ev, input bit rd_, input bit wr, input bit m2r,
                       input bit rw, input logic [7:0] alu, input logic [7:0] sd, input logic [2:0] rd);
    int         waited;
    int         idx;
    logic [7:0] expd;
    @(negedge clk);
    ev_v[k] = ev; mrd_v[k] = rd_; mwr_v[k] = wr; m2r_v[k] = m2r; rw_v[k] = rw;
    alu_v[k] = alu; sd_v[k] = sd; rd_v[k] = rd; flush_v[k] = 1'b0;
    #1;
    check("fwd_data", fwd_v[k], alu);
    check("fwd_rd", frd_v[k], rd);
    check("fwd_we", fwe_v[k], rw & ev);
    waited = 0;
    while (stall_v[k] && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("stall_cycles", waited, (ev && (rd_ || wr)) ? ws(k) : 0);
    idx  = int'(alu) % dep(k);
    expd = (m2r && !(rd_ && wr)) ? mm[k][idx] : alu;
    if (ev && rw) expq.push_back('{k, expd, rd});
    if (ev && wr) mm[k][idx] = sd;
    @(posedge clk);
    #1;
    drive_idle(k);
  endtask

  // Memory op killed by flush after cb stall cycles: no write, bubble into MEM/WB.
  task automatic flush_op(input int k, input bit is_store, input logic [7:0] alu,
                          input logic [7:0] sd, input logic [2:0] rd, input int cb);
    @(negedge clk);
    ev_v[k] = 1'b1; mrd_v[k] = !is_store; mwr_v[k] = is_store; m2r_v[k] = !is_store;
    rw_v[k] = 1'b1; alu_v[k] = alu; sd_v[k] = sd; rd_v[k] = rd;
    repeat (cb) @(negedge clk);
    flush_v[k] = 1'b1;
    #1;
    check("flush_no_stall", stall_v[k], 1'b0);
    @(posedge clk);
    #1;
    check("flush_bubble", wbwe_v[k], 1'b0);
    drive_idle(k);
  endtask

  task automatic reset_mid_store(input logic [7:0] alu, input logic [7:0] sd);
    @(negedge clk);
    ev_v[0] = 1'b1; mwr_v[0] = 1'b1; mrd_v[0] = 1'b0; m2r_v[0] = 1'b0; rw_v[0] = 1'b0;
    alu_v[0] = alu; sd_v[0] = sd; rd_v[0] = 3'd1;
    #1;
    check("rst_pre_stall", stall_v[0], 1'b1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_wb_data", wbd_v[0], 8'h00);
    check("rst_async_wb_rd", wbrd_v[0], 3'd0);
    check("rst_async_wb_we", wbwe_v[0], 1'b0);
    check("rst_async_stall", stall_v[0], 1'b0);
    drive_idle(0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every visible write-back must match the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (wbwe_v[k]) begin
          if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wb_unexpected dut%0d: got data 0x%0h rd %0d, required no write-back",
                     k, wbd_v[k], wbrd_v[k]);
          end else begin
            e = expq.pop_front();
            check("wb_dut", k, e.k);
            check("wb_data", wbd_v[k], e.data);
            check("wb_rd", wbrd_v[k], e.rd);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    int         kind;
    logic [7:0] a;
    logic [7:0] s;
    logic [2:0] r;
    bit         ev;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    drive_idle(0);
    drive_idle(1);
    alu_v = '0; sd_v = '0; rd_v = '0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_wb_data", wbd_v[k], 8'h00);
      check("reset_wb_rd", wbrd_v[k], 3'd0);
      check("reset_wb_we", wbwe_v[k], 1'b0);
      check("reset_stall", stall_v[k], 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < dep(k); i++) begin
        s = 8'($urandom);
        issue(k, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'(i), s, 3'd0);
      end
    end

    // Store 5A then load it back (address wraps to 0 in the 16-entry memory).
    issue(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h5A, 3'd0);
    issue(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 8'h00, 3'd3);
    // Plain ALU op with a negative result.
    issue(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF9, 8'h00, 3'd2);
    // Flushed load in flight, then flushed store to address 4, then read address 4.
    flush_op(0, 1'b0, 8'h08, 8'h00, 3'd4, 1);
    flush_op(0, 1'b1, 8'h04, 8'hEE, 3'd4, 1);
    issue(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 8'h00, 3'd4);
    // Address wrap.
    issue(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h25, 8'h33, 3'd0);
    issue(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 8'h00, 3'd7);
    // Reset in the middle of a store; the old value at address 7 must survive.
    issue(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h6C, 8'h00, 3'd5);
    reset_mid_store(8'h07, 8'hC3);
    issue(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 8'h00, 3'd6);
    // Zero-wait instance: back-to-back store then load of the same address.
    issue(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC8, 8'h81, 3'd0);
    issue(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC8, 8'h00, 3'd6);
    flush_op(1, 1'b1, 8'hC8, 8'h11, 3'd1, 0);
    issue(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC8, 8'h00, 3'd2);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 150; i++) begin
        kind = $urandom_range(0, 9);
        a    = 8'($urandom);
        s    = 8'($urandom);
        r    = 3'($urandom);
        ev   = ($urandom_range(0, 7) != 0);
        case (kind)
          0, 1, 2: issue(k, ev, 1'b0, 1'b0, 1'b0, 1'($urandom), a, s, r);
          3, 4, 5: issue(k, ev, 1'b1, 1'b0, 1'b1, 1'($urandom), a, s, r);
          6, 7:    issue(k, ev, 1'b0, 1'b1, ($urandom_range(0, 3) == 0), 1'($urandom), a, s, r);
          8:       issue(k, ev, 1'b1, 1'b1, 1'($urandom), 1'b1, a, s, r);
          default: flush_op(k, 1'($urandom), a, s, r, $urandom_range(0, ws(k)));
        endcase
      end
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drain", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
